iop_to_ahb_master: RTL and testbench

//  Converts single IOP-style transactions from a local requester (DMA or test

---
 rtl/iop_to_ahb_master.sv | 201 ++++++++++++++++++++
 tb/tb_iop_to_ahb_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iop_to_ahb_master.sv
// Single-transfer IOP request to AHB-Lite master bridge. Each accepted request
// becomes one non-pipelined SINGLE transfer; misaligned or illegal sizes are rejected locally.
module iop_to_ahb_master #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
   parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  IOSEL,
   input  logic                  IOTRANS,
   input  logic                  IOWRITE,
   input  logic [1:0]            IOSIZE,
   input  logic [ADDR_WIDTH-1:0] IOADDR,
   input  logic [31:0]           IOWDATA,
   output logic                  IOREADY,
   output logic                  IODONE,
   output logic                  IORESP,
   output logic [31:0]           IORDATA,
   output logic [31:0]           HADDR,
   output logic [1:0]            HTRANS,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic [31:0]           HWDATA,
   input  logic [31:0]           HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP
);

   // state   | meaning
   // ST_IDLE | waiting for a request, IOREADY high
   // ST_ADDR | AHB address phase, NONSEQ driven until HREADY
   // ST_DATA | AHB data phase, waiting for HREADY to complete
   // ST_REJ  | illegal request, report error next cycle without bus access
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_REJ  = 2'd3
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_t      state_q, state_d;

   logic        ioready_q, ioready_d;
   logic        iodone_q,  iodone_d;
   logic        ioresp_q,  ioresp_d;
   logic [31:0] iordata_q, iordata_d;
   logic [31:0] haddr_q,   haddr_d;
   logic [1:0]  htrans_q,  htrans_d;
   logic        hwrite_q,  hwrite_d;
   logic [2:0]  hsize_q,   hsize_d;
   logic [31:0] hwdata_q,  hwdata_d;
   logic [31:0] wdata_q,   wdata_d;

   logic        accept;
   logic        illegal;

   assign accept = IOSEL & IOTRANS & ioready_q;

   always_comb begin
      illegal = 1'b0;
      case (IOSIZE)
         2'b01:   illegal = IOADDR[0];
         2'b10:   illegal = (IOADDR[1:0] != 2'b00);
         2'b11:   illegal = 1'b1;
         default: illegal = 1'b0;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = illegal ? ST_REJ : ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (HREADY) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (HREADY) begin
               state_d = ST_IDLE;
            end
         end
         ST_REJ:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Computes the next value of every registered output; all bus and IOP
   // outputs come straight from flops.
   always_comb begin
      ioready_d = ioready_q;
      iodone_d  = 1'b0;
      ioresp_d  = ioresp_q;
      iordata_d = iordata_q;
      haddr_d   = haddr_q;
      htrans_d  = htrans_q;
      hwrite_d  = hwrite_q;
      hsize_d   = hsize_q;
      hwdata_d  = hwdata_q;
      wdata_d   = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               ioready_d = 1'b0;
               if (!illegal) begin
                  haddr_d  = {BASE_ADDR[31:ADDR_WIDTH], IOADDR};
                  htrans_d = HTRANS_NONSEQ;
                  hwrite_d = IOWRITE;
                  hsize_d  = {1'b0, IOSIZE};
                  wdata_d  = IOWDATA;
               end
            end
         end
         ST_ADDR: begin
            if (HREADY) begin
               htrans_d = HTRANS_IDLE;
               if (hwrite_q) begin
                  hwdata_d = wdata_q;
               end
            end
         end
         ST_DATA: begin
            // The first ERROR cycle has HREADY low, so it simply extends the wait.
            if (HREADY) begin
               iodone_d  = 1'b1;
               ioready_d = 1'b1;
               ioresp_d  = HRESP;
               if (!hwrite_q) begin
                  iordata_d = HRDATA;
               end
            end
         end
         ST_REJ: begin
            iodone_d  = 1'b1;
            ioresp_d  = 1'b1;
            ioready_d = 1'b1;
         end
         default: begin
            htrans_d  = HTRANS_IDLE;
            ioready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ioready_q <= 1'b1;
         iodone_q  <= 1'b0;
         ioresp_q  <= 1'b0;
         iordata_q <= 32'h0;
         haddr_q   <= 32'h0;
         htrans_q  <= HTRANS_IDLE;
         hwrite_q  <= 1'b0;
         hsize_q   <= 3'b000;
         hwdata_q  <= 32'h0;
         wdata_q   <= 32'h0;
      end else begin
         ioready_q <= ioready_d;
         iodone_q  <= iodone_d;
         ioresp_q  <= ioresp_d;
         iordata_q <= iordata_d;
         haddr_q   <= haddr_d;
         htrans_q  <= htrans_d;
         hwrite_q  <= hwrite_d;
         hsize_q   <= hsize_d;
         hwdata_q  <= hwdata_d;
         wdata_q   <= wdata_d;
      end
   end

   assign IOREADY = ioready_q;
   assign IODONE  = iodone_q;
   assign IORESP  = ioresp_q;
   assign IORDATA = iordata_q;
   assign HADDR   = haddr_q;
   assign HTRANS  = htrans_q;
   assign HWRITE  = hwrite_q;
   assign HSIZE   = hsize_q;
   assign HWDATA  = hwdata_q;
   assign HBURST  = 3'b000;
   assign HPROT   = HPROT_VAL;

endmodule

// File: tb/tb_iop_to_ahb_master.sv
// Directed bench for iop_to_ahb_master: one task per scenario, expected values
// worked out by hand from the transfer timing.
module tb_iop_to_ahb_master;

   logic        HCLK;
   logic        HRESETn;
   logic        IOSEL;
   logic        IOTRANS;
   logic        IOWRITE;
   logic [1:0]  IOSIZE;
   logic [11:0] IOADDR;
   logic [31:0] IOWDATA;
   logic        IOREADY;
   logic        IODONE;
   logic        IORESP;
   logic [31:0] IORDATA;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   int checks = 0;
   int errors = 0;

   iop_to_ahb_master dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .IOSEL   (IOSEL),
      .IOTRANS (IOTRANS),
      .IOWRITE (IOWRITE),
      .IOSIZE  (IOSIZE),
      .IOADDR  (IOADDR),
      .IOWDATA (IOWDATA),
      .IOREADY (IOREADY),
      .IODONE  (IODONE),
      .IORESP  (IORESP),
      .IORDATA (IORDATA),
      .HADDR   (HADDR),
      .HTRANS  (HTRANS),
      .HWRITE  (HWRITE),
      .HSIZE   (HSIZE),
      .HBURST  (HBURST),
      .HPROT   (HPROT),
      .HWDATA  (HWDATA),
      .HRDATA  (HRDATA),
      .HREADY  (HREADY),
      .HRESP   (HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive_req(input logic wr, input logic [1:0] sz, input logic [11:0] a,
                            input logic [31:0] d);
      IOSEL   = 1'b1;
      IOTRANS = 1'b1;
      IOWRITE = wr;
      IOSIZE  = sz;
      IOADDR  = a;
      IOWDATA = d;
   endtask

   task automatic drop_req();
      IOSEL   = 1'b0;
      IOTRANS = 1'b0;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      repeat (2) tick();
      checks++; if (IOREADY !== 1'b1) begin errors++; $display("FAIL reset_ioready got %b want 1", IOREADY); end
      checks++; if ({IODONE, IORESP} !== 2'b00) begin errors++; $display("FAIL reset_done_resp got %b want 00", {IODONE, IORESP}); end
      checks++; if (IORDATA !== 32'h0) begin errors++; $display("FAIL reset_iordata got %h want 0", IORDATA); end
      checks++; if ({HADDR, HTRANS, HWRITE, HSIZE} !== 38'h0) begin errors++; $display("FAIL reset_haddr_ctl got %h want 0", {HADDR, HTRANS, HWRITE, HSIZE}); end
      checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL reset_hwdata got %h want 0", HWDATA); end
      checks++; if ({HBURST, HPROT} !== 7'b000_0011) begin errors++; $display("FAIL reset_consts got %b want 0000011", {HBURST, HPROT}); end
      HRESETn = 1'b1;
      tick();
      checks++; if (IOREADY !== 1'b1 || HTRANS !== 2'b00) begin errors++; $display("FAIL post_reset_idle got rdy=%b trans=%b want 1/00", IOREADY, HTRANS); end
   endtask

   task automatic test_word_write();
      HRDATA = 32'hFFFF_0000;
      drive_req(1'b1, 2'b10, 12'h0A4, 32'hDEAD_BEEF);
      tick();
      drop_req();
      checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL ww_nonseq got %b want 10", HTRANS); end
      checks++; if (HADDR !== 32'h4000_00A4) begin errors++; $display("FAIL ww_haddr got %h want 400000a4", HADDR); end
      checks++; if ({HWRITE, HSIZE} !== 4'b1010) begin errors++; $display("FAIL ww_ctl got %b want 1010", {HWRITE, HSIZE}); end
      checks++; if ({IOREADY, IODONE} !== 2'b00) begin errors++; $display("FAIL ww_busy got %b want 00", {IOREADY, IODONE}); end
      tick();
      checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL ww_data_idle got %b want 00", HTRANS); end
      checks++; if (HWDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ww_hwdata got %h want deadbeef", HWDATA); end
      checks++; if (IODONE !== 1'b0) begin errors++; $display("FAIL ww_early_done got %b want 0", IODONE); end
      tick();
      checks++; if ({IODONE, IORESP, IOREADY} !== 3'b101) begin errors++; $display("FAIL ww_done got %b want 101", {IODONE, IORESP, IOREADY}); end
      checks++; if (IORDATA !== 32'h0) begin errors++; $display("FAIL ww_iordata_kept got %h want 0", IORDATA); end
      tick();
      checks++; if (IODONE !== 1'b0) begin errors++; $display("FAIL ww_done_pulse got %b want 0", IODONE); end
   endtask

   task automatic test_byte_read();
      drive_req(1'b0, 2'b00, 12'h013, 32'h0);
      tick();
      drop_req();
      checks++; if ({HTRANS, HWRITE, HSIZE} !== 6'b10_0_000) begin errors++; $display("FAIL br_ctl got %b want 100000", {HTRANS, HWRITE, HSIZE}); end
      checks++; if (HADDR !== 32'h4000_0013) begin errors++; $display("FAIL br_haddr got %h want 40000013", HADDR); end
      tick();
      HREADY = 1'b0;
      HRDATA = 32'hAAAA_AAAA;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if ({IODONE, HTRANS} !== 3'b000) begin errors++; $display("FAIL br_wait%0d got %b want 000", i, {IODONE, HTRANS}); end
      end
      HREADY = 1'b1;
      HRDATA = 32'h1234_5678;
      tick();
      checks++; if ({IODONE, IORESP} !== 2'b10) begin errors++; $display("FAIL br_done got %b want 10", {IODONE, IORESP}); end
      checks++; if (IORDATA !== 32'h1234_5678) begin errors++; $display("FAIL br_iordata got %h want 12345678", IORDATA); end
   endtask

   task automatic test_error_read();
      int dones;
      dones = 0;
      drive_req(1'b0, 2'b10, 12'h100, 32'h0);
      tick();
      drop_req();
      tick();
      HRESP  = 1'b1;
      HREADY = 1'b0;
      HRDATA = 32'hBAD0_BAD0;
      tick();
      dones += int'(IODONE);
      checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL er_trans_c1 got %b want 00", HTRANS); end
      HREADY = 1'b1;
      tick();
      dones += int'(IODONE);
      checks++; if ({IODONE, IORESP, HTRANS} !== 4'b1100) begin errors++; $display("FAIL er_done got %b want 1100", {IODONE, IORESP, HTRANS}); end
      HRESP = 1'b0;
      tick();
      dones += int'(IODONE);
      checks++; if (IORESP !== 1'b1) begin errors++; $display("FAIL er_resp_hold got %b want 1", IORESP); end
      checks++; if (dones != 1) begin errors++; $display("FAIL er_done_count got %0d want 1", dones); end
   endtask

   task automatic test_illegal();
      logic [1:0]  szs [3];
      logic [11:0] adrs [3];
      szs  = '{2'b11, 2'b01, 2'b10};
      adrs = '{12'h010, 12'h001, 12'h002};
      for (int i = 0; i < 3; i++) begin
         drive_req(1'b1, szs[i], adrs[i], 32'h1111_1111);
         tick();
         drop_req();
         checks++; if ({HTRANS, IOREADY, IODONE} !== 4'b0000) begin errors++; $display("FAIL il%0d_rej got %b want 0000", i, {HTRANS, IOREADY, IODONE}); end
         tick();
         checks++; if ({IODONE, IORESP, IOREADY, HTRANS} !== 5'b11100) begin errors++; $display("FAIL il%0d_done got %b want 11100", i, {IODONE, IORESP, IOREADY, HTRANS}); end
         tick();
         checks++; if ({IODONE, HTRANS} !== 3'b000) begin errors++; $display("FAIL il%0d_after got %b want 000", i, {IODONE, HTRANS}); end
      end
   endtask

   task automatic test_back_to_back();
      drive_req(1'b1, 2'b10, 12'h0A8, 32'h0102_0304);
      tick();
      drop_req();
      tick();
      tick();
      checks++; if ({IODONE, IORESP, IOREADY} !== 3'b101) begin errors++; $display("FAIL b2b_done1 got %b want 101", {IODONE, IORESP, IOREADY}); end
      drive_req(1'b0, 2'b01, 12'h0FE, 32'h0);
      tick();
      drop_req();
      checks++; if ({HTRANS, HSIZE, IODONE} !== 6'b10_001_0) begin errors++; $display("FAIL b2b_accept got %b want 100010", {HTRANS, HSIZE, IODONE}); end
      checks++; if (HADDR !== 32'h4000_00FE) begin errors++; $display("FAIL b2b_haddr got %h want 400000fe", HADDR); end
      checks++; if (IORDATA !== 32'hBAD0_BAD0) begin errors++; $display("FAIL b2b_write_keeps_iordata got %h want bad0bad0", IORDATA); end
      HRDATA = 32'h0000_CAFE;
      tick();
      tick();
      checks++; if ({IODONE, IORESP} !== 2'b10 || IORDATA !== 32'h0000_CAFE) begin errors++; $display("FAIL b2b_done2 got %b %h want 10 0000cafe", {IODONE, IORESP}, IORDATA); end
   endtask

   task automatic test_addr_wait();
      HREADY = 1'b0;
      drive_req(1'b1, 2'b10, 12'h0C8, 32'h55AA_55AA);
      tick();
      drive_req(1'b0, 2'b00, 12'h3FF, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 0) drop_req();
         checks++; if ({HTRANS, HSIZE, IOREADY} !== 6'b10_010_0 || HADDR !== 32'h4000_00C8) begin errors++; $display("FAIL aw_hold%0d got %b %h want 100100 400000c8", i, {HTRANS, HSIZE, IOREADY}, HADDR); end
      end
      HREADY = 1'b1;
      tick();
      checks++; if (HTRANS !== 2'b00 || HWDATA !== 32'h55AA_55AA) begin errors++; $display("FAIL aw_data got %b %h want 00 55aa55aa", HTRANS, HWDATA); end
      tick();
      checks++; if ({IODONE, IORESP} !== 2'b10) begin errors++; $display("FAIL aw_done got %b want 10", {IODONE, IORESP}); end
      tick();
      checks++; if ({HTRANS, IOREADY, IODONE} !== 4'b0010 || HADDR !== 32'h4000_00C8) begin errors++; $display("FAIL aw_ignored got %b %h want 0010 400000c8", {HTRANS, IOREADY, IODONE}, HADDR); end
   endtask

   task automatic test_reset_mid();
      int dones;
      dones = 0;
      drive_req(1'b1, 2'b10, 12'h0F0, 32'hCAFE_F00D);
      tick();
      drop_req();
      tick();
      checks++; if (HWDATA !== 32'hCAFE_F00D) begin errors++; $display("FAIL rm_in_data got %h want cafef00d", HWDATA); end
      HRESETn = 1'b0;
      #1;
      checks++; if ({IOREADY, IODONE, IORESP, HTRANS, HWRITE, HSIZE} !== 9'b100_00_0_000) begin errors++; $display("FAIL rm_async_ctl got %b want 100000000", {IOREADY, IODONE, IORESP, HTRANS, HWRITE, HSIZE}); end
      checks++; if ({HADDR, HWDATA, IORDATA} !== 96'h0) begin errors++; $display("FAIL rm_async_data got %h want 0", {HADDR, HWDATA, IORDATA}); end
      tick();
      dones += int'(IODONE);
      HRESETn = 1'b1;
      repeat (2) begin
         tick();
         dones += int'(IODONE);
      end
      checks++; if (dones != 0 || IOREADY !== 1'b1 || HTRANS !== 2'b00) begin errors++; $display("FAIL rm_after got dones=%0d rdy=%b trans=%b want 0/1/00", dones, IOREADY, HTRANS); end
   endtask

   initial begin
      HRESETn = 1'b0;
      IOSEL   = 1'b0;
      IOTRANS = 1'b0;
      IOWRITE = 1'b0;
      IOSIZE  = 2'b00;
      IOADDR  = 12'h0;
      IOWDATA = 32'h0;
      HRDATA  = 32'h0;
      HREADY  = 1'b1;
      HRESP   = 1'b0;
      test_reset();
      test_word_write();
      test_byte_read();
      test_error_read();
      test_illegal();
      test_back_to_back();
      test_addr_wait();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
